// File: rtl/fc_pkg.sv
// Shared FC-layer types and default sizes.
// Holds the handoff state encoding used by the layer handshake logic.
// No logic; imported by the handoff block and its bank.
package fc_pkg;

    localparam int FC_DATA_WIDTH = 32;
    localparam int FC_IFM_DEPTH  = 84;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ARM   = 2'd1,
        ST_SERVE = 2'd2
    } handoff_state_t;

endpackage

// File: rtl/fc_ifm_bank.sv
// IFM_DEPTH x DATA_WIDTH register file holding one input feature-map frame.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none; the caller gates we. Out-of-range reads return 0.
module fc_ifm_bank
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int IFM_DEPTH  = FC_IFM_DEPTH,
    parameter int ADDR_W     = $clog2(IFM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [IFM_DEPTH];

    // Storage: cleared on reset, one word written per accepted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < IFM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(waddr) < IFM_DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < IFM_DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/fc_ifm_handoff.sv
// Collects one IFM frame from the upstream layer and hands it to the downstream FC controller.
// Latency: start_to_next can fire the cycle after the last word; ifm_data is combinational.
// Backpressure: wr_ready low while no bank is free (FC_HANDOFF_PINGPONG_EN selects two banks).
module fc_ifm_handoff
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int IFM_DEPTH  = FC_IFM_DEPTH,
    parameter int ADDR_W     = $clog2(IFM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  end_to_previous,
    output logic                  start_to_next,
    input  logic [ADDR_W-1:0]     sel_ifm,
    output logic [DATA_WIDTH-1:0] ifm_data,
    output logic                  frame_done,
    output logic                  busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IFM_DEPTH - 1);

    handoff_state_t    state_q, state_d;
    logic [ADDR_W-1:0] wr_idx_q;
    logic              seen_busy_q, seen_busy_d;
    logic              wr_accept;
    logic              last_word;
    logic              other_armed;   // another full frame is ready when the current one is released

    assign wr_accept = wr_valid & wr_ready;
    assign last_word = wr_accept & (wr_idx_q == LAST_IDX);
    assign busy      = (state_q != ST_FILL);

`ifdef FC_HANDOFF_PINGPONG_EN
    logic                  fill_sel_q;
    logic                  serve_sel_q;
    logic [1:0]            bank_full_q;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;

    // Upstream only stalls when the bank it points at is still armed or being served.
    assign wr_ready    = ~bank_full_q[fill_sel_q];
    // During SERVE the fill side can only be on the other bank, so last_word means it just filled.
    assign other_armed = bank_full_q[~serve_sel_q] | last_word;
    assign ifm_data    = serve_sel_q ? rdata1 : rdata0;

    // Bank ownership: a bank becomes full on its last word and is freed by frame_done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_sel_q  <= 1'b0;
            serve_sel_q <= 1'b0;
            bank_full_q <= 2'b00;
        end else begin
            if (last_word) begin
                bank_full_q[fill_sel_q] <= 1'b1;
                fill_sel_q              <= ~fill_sel_q;
            end
            if (frame_done) begin
                bank_full_q[serve_sel_q] <= 1'b0;
                serve_sel_q              <= ~serve_sel_q;
            end
        end
    end

    fc_ifm_bank #(.DATA_WIDTH(DATA_WIDTH), .IFM_DEPTH(IFM_DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (wr_accept & ~fill_sel_q),
        .waddr (wr_idx_q),
        .wdata (wr_data),
        .raddr (sel_ifm),
        .rdata (rdata0)
    );

    fc_ifm_bank #(.DATA_WIDTH(DATA_WIDTH), .IFM_DEPTH(IFM_DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (wr_accept & fill_sel_q),
        .waddr (wr_idx_q),
        .wdata (wr_data),
        .raddr (sel_ifm),
        .rdata (rdata1)
    );
`else
    // Single bank: the frame being served must not be overwritten, so upstream waits.
    assign wr_ready    = (state_q == ST_FILL);
    assign other_armed = 1'b0;

    fc_ifm_bank #(.DATA_WIDTH(DATA_WIDTH), .IFM_DEPTH(IFM_DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (wr_accept),
        .waddr (wr_idx_q),
        .wdata (wr_data),
        .raddr (sel_ifm),
        .rdata (ifm_data)
    );
`endif

    // Write index: advances per accepted word, wraps after the last word of a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_idx_q <= '0;
        end else if (wr_accept) begin
            wr_idx_q <= last_word ? '0 : wr_idx_q + 1'b1;
        end
    end

    // State and sticky downstream-busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FILL;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seen_busy_q <= seen_busy_d;
        end
    end

    // Next state plus start/release pulses; downstream must go busy before a release counts.
    always_comb begin
        state_d       = state_q;
        seen_busy_d   = seen_busy_q;
        start_to_next = 1'b0;
        frame_done    = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (last_word) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (end_to_previous) begin
                    start_to_next = 1'b1;
                    state_d       = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (seen_busy_q && end_to_previous) begin
                    frame_done  = 1'b1;
                    seen_busy_d = 1'b0;
                    state_d     = other_armed ? ST_ARM : ST_FILL;
                end else if (!end_to_previous) begin
                    seen_busy_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_FILL;
                seen_busy_d = 1'b0;
            end
        endcase
    end

endmodule
